// File: rtl/cpu_ask2_pio_pulse_out_if.sv
// rtl/cpu_ask2_pio_pulse_out_if.sv - Avalon-MM register bus bundle for the pulse PIO
interface cpu_ask2_pio_pulse_out_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        read;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, read, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, read, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/cpu_ask2_pio_pulse_out.sv
// rtl/cpu_ask2_pio_pulse_out.sv - Avalon-MM PIO output with set/clear and timed pulse inversion
// Pulse logic (PULSE, PULSE_LEN, STATUS) exists only when CPU_ASK2_PIO_PULSE_EN is defined.
module cpu_ask2_pio_pulse_out #(
   parameter int                 WIDTH       = 8,
   parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
   parameter int                 LEN_W       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   cpu_ask2_pio_pulse_out_if.slave bus,
   output logic [WIDTH-1:0]      out_port
);

   localparam logic [2:0] A_DATA      = 3'd0;
   localparam logic [2:0] A_OUTSET    = 3'd2;
   localparam logic [2:0] A_OUTCLEAR  = 3'd3;
`ifdef CPU_ASK2_PIO_PULSE_EN
   localparam logic [2:0] A_PULSE     = 3'd4;
   localparam logic [2:0] A_PULSE_LEN = 3'd5;
   localparam logic [2:0] A_STATUS    = 3'd6;
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
`endif

   logic             w_wr;
   logic             w_rd;
   logic [WIDTH-1:0] w_wd;
   logic [31:0]      w_rdata;
   logic             w_unused;
   logic [WIDTH-1:0] r_data;
   logic [31:0]      r_readdata;

   assign w_wr     = bus.chipselect & ~bus.write_n;
   assign w_rd     = bus.chipselect & bus.read;
   assign w_wd     = bus.writedata[WIDTH-1:0];
   assign w_unused = ^bus.writedata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data <= RESET_VALUE;
      end else if (w_wr) begin
         case (bus.address)
            A_DATA:     r_data <= w_wd;
            A_OUTSET:   r_data <= r_data | w_wd;
            A_OUTCLEAR: r_data <= r_data & ~w_wd;
            default:    ;
         endcase
      end
   end

`ifdef CPU_ASK2_PIO_PULSE_EN
   logic [LEN_W-1:0] r_pulse_len;
   logic [LEN_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_pulse_mask;
   logic [WIDTH-1:0] w_mask_eff;
   logic             w_busy;
   logic             w_last;
   logic             w_pulse_start;

   assign w_busy        = (r_cnt != '0);
   assign w_last        = (r_cnt == LEN_ONE);
   // A retrigger landing on the final count cycle starts a fresh mask, not an extension.
   assign w_mask_eff    = w_last ? '0 : r_pulse_mask;
   assign w_pulse_start = w_wr && (bus.address == A_PULSE) &&
                          (w_wd != '0) && (r_pulse_len != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pulse_len <= '0;
      end else if (w_wr && (bus.address == A_PULSE_LEN)) begin
         r_pulse_len <= bus.writedata[LEN_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pulse_mask <= '0;
         r_cnt        <= '0;
      end else if (w_pulse_start) begin
         r_pulse_mask <= w_mask_eff | w_wd;
         r_cnt        <= r_pulse_len;
      end else if (w_busy) begin
         r_cnt <= r_cnt - LEN_ONE;
         if (w_last) begin
            r_pulse_mask <= '0;
         end
      end
   end

   assign out_port = r_data ^ r_pulse_mask;
`else
   assign out_port = r_data;
`endif

   always_comb begin
      w_rdata = '0;
      case (bus.address)
         A_DATA:      w_rdata = 32'(r_data);
`ifdef CPU_ASK2_PIO_PULSE_EN
         A_PULSE_LEN: w_rdata = 32'(r_pulse_len);
         A_STATUS:    w_rdata = {31'b0, w_busy};
`endif
         default:     w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_readdata <= '0;
      end else if (w_rd) begin
         r_readdata <= w_rdata;
      end
   end

   assign bus.readdata = r_readdata;

endmodule

// File: tb/tb_cpu_ask2_pio_pulse_out.sv
// tb/tb_cpu_ask2_pio_pulse_out.sv - directed self-checking bench for cpu_ask2_pio_pulse_out
// Pulse scenarios run when CPU_ASK2_PIO_PULSE_EN is defined; otherwise the disabled map is checked.
module tb_cpu_ask2_pio_pulse_out;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] out_port;
   int         n_checks = 0;
   int         n_errors = 0;

   cpu_ask2_pio_pulse_out_if bus ();

   cpu_ask2_pio_pulse_out #(
      .WIDTH       (8),
      .RESET_VALUE (8'hA5),
      .LEN_W       (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .out_port (out_port)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a);
      @(negedge clk);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.read       = 1'b1;
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      n_checks++;
      if (out_port !== 8'hA5) begin
         n_errors++;
         $display("FAIL reset_out: got %h expected a5", out_port);
      end
      n_checks++;
      if (bus.readdata !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_readdata: got %h expected 00000000", bus.readdata);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      n_checks++;
      if (out_port !== 8'hA5) begin
         n_errors++;
         $display("FAIL release_out: got %h expected a5", out_port);
      end
      bus_read(3'd0);
      n_checks++;
      if (bus.readdata !== 32'h000000A5) begin
         n_errors++;
         $display("FAIL reset_data_read: got %h expected 000000a5", bus.readdata);
      end
   endtask

   task automatic test_set_clear();
      bus_write(3'd0, 32'h0000000F);
      bus_write(3'd2, 32'h00000030);
      bus_write(3'd3, 32'h00000003);
      n_checks++;
      if (out_port !== 8'h3C) begin
         n_errors++;
         $display("FAIL set_clear_out: got %h expected 3c", out_port);
      end
      bus_read(3'd0);
      n_checks++;
      if (bus.readdata !== 32'h0000003C) begin
         n_errors++;
         $display("FAIL set_clear_read: got %h expected 0000003c", bus.readdata);
      end
   endtask

   task automatic test_reserved_and_hold();
      logic [2:0] addrs [4];
      addrs = '{3'd1, 3'd7, 3'd2, 3'd3};
      bus_write(3'd1, 32'hFFFFFFFF);
      bus_write(3'd7, 32'hFFFFFFFF);
      n_checks++;
      if (out_port !== 8'h3C) begin
         n_errors++;
         $display("FAIL reserved_write: got %h expected 3c", out_port);
      end
      for (int i = 0; i < 4; i++) begin
         bus_read(addrs[i]);
         n_checks++;
         if (bus.readdata !== 32'h0) begin
            n_errors++;
            $display("FAIL read_zero_addr%0d: got %h expected 00000000", addrs[i], bus.readdata);
         end
      end
      bus_read(3'd0);
      repeat (3) tick();
      bus_write(3'd0, 32'h00000055);
      n_checks++;
      if (bus.readdata !== 32'h0000003C) begin
         n_errors++;
         $display("FAIL readdata_hold: got %h expected 0000003c", bus.readdata);
      end
      n_checks++;
      if (out_port !== 8'h55) begin
         n_errors++;
         $display("FAIL data_write: got %h expected 55", out_port);
      end
   endtask

`ifdef CPU_ASK2_PIO_PULSE_EN
   task automatic test_pulse_basic();
      logic exp;
      bus_write(3'd5, 32'd5);
      bus_write(3'd0, 32'h0);
      bus_read(3'd5);
      n_checks++;
      if (bus.readdata !== 32'd5) begin
         n_errors++;
         $display("FAIL pulse_len_read: got %h expected 00000005", bus.readdata);
      end
      bus_write(3'd4, 32'h01);
      for (int k = 0; k < 7; k++) begin
         exp = (k < 5);
         n_checks++;
         if (out_port !== {7'b0, exp}) begin
            n_errors++;
            $display("FAIL pulse_basic_k%0d: got %h expected %h", k, out_port, {7'b0, exp});
         end
         tick();
      end
      bus_read(3'd6);
      n_checks++;
      if (bus.readdata !== 32'h0) begin
         n_errors++;
         $display("FAIL status_idle: got %h expected 00000000", bus.readdata);
      end
      bus_write(3'd4, 32'h01);
      bus_read(3'd6);
      n_checks++;
      if (bus.readdata !== 32'h1) begin
         n_errors++;
         $display("FAIL status_busy: got %h expected 00000001", bus.readdata);
      end
      repeat (10) tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp;
      bus_write(3'd5, 32'd4);
      bus_write(3'd4, 32'h01);
      for (int k = 0; k < 8; k++) begin
         exp = {6'b0, (k >= 2 && k < 6), (k < 6)};
         n_checks++;
         if (out_port !== exp) begin
            n_errors++;
            $display("FAIL retrigger_k%0d: got %h expected %h", k, out_port, exp);
         end
         if (k == 1) bus_write(3'd4, 32'h02);
         else tick();
      end
   endtask

   task automatic test_ignored_and_end_retrigger();
      logic [7:0] exp;
      bus_write(3'd5, 32'd0);
      bus_write(3'd4, 32'hFF);
      n_checks++;
      if (out_port !== 8'h00) begin
         n_errors++;
         $display("FAIL ignored_pulse_out: got %h expected 00", out_port);
      end
      bus_read(3'd6);
      n_checks++;
      if (bus.readdata !== 32'h0) begin
         n_errors++;
         $display("FAIL ignored_pulse_busy: got %h expected 00000000", bus.readdata);
      end
      bus_write(3'd5, 32'd3);
      bus_write(3'd4, 32'h00);
      n_checks++;
      if (out_port !== 8'h00) begin
         n_errors++;
         $display("FAIL zero_mask_pulse: got %h expected 00", out_port);
      end
      bus_write(3'd4, 32'h01);
      for (int k = 0; k < 7; k++) begin
         exp = (k < 3) ? 8'h01 : (k < 6) ? 8'h04 : 8'h00;
         n_checks++;
         if (out_port !== exp) begin
            n_errors++;
            $display("FAIL end_retrigger_k%0d: got %h expected %h", k, out_port, exp);
         end
         if (k == 2) bus_write(3'd4, 32'h04);
         else tick();
      end
   endtask

   task automatic test_writes_during_pulse();
      logic [7:0] exp_tab [5];
      exp_tab = '{8'h01, 8'hF1, 8'hF1, 8'hF0, 8'hF0};
      bus_write(3'd5, 32'd3);
      bus_write(3'd4, 32'h01);
      for (int k = 0; k < 5; k++) begin
         n_checks++;
         if (out_port !== exp_tab[k]) begin
            n_errors++;
            $display("FAIL during_pulse_k%0d: got %h expected %h", k, out_port, exp_tab[k]);
         end
         if (k == 0) bus_write(3'd0, 32'hF0);
         else if (k == 1) bus_write(3'd5, 32'd10);
         else tick();
      end
   endtask

   task automatic test_mid_pulse_reset();
      bus_write(3'd0, 32'h0);
      bus_write(3'd5, 32'd100);
      bus_write(3'd4, 32'h80);
      repeat (10) tick();
      n_checks++;
      if (out_port !== 8'h80) begin
         n_errors++;
         $display("FAIL long_pulse_out: got %h expected 80", out_port);
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if (out_port !== 8'hA5) begin
         n_errors++;
         $display("FAIL mid_reset_out: got %h expected a5", out_port);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      bus_read(3'd6);
      n_checks++;
      if (bus.readdata !== 32'h0) begin
         n_errors++;
         $display("FAIL mid_reset_busy: got %h expected 00000000", bus.readdata);
      end
      bus_read(3'd5);
      n_checks++;
      if (bus.readdata !== 32'h0) begin
         n_errors++;
         $display("FAIL mid_reset_len: got %h expected 00000000", bus.readdata);
      end
      repeat (5) tick();
      n_checks++;
      if (out_port !== 8'hA5) begin
         n_errors++;
         $display("FAIL no_resume: got %h expected a5", out_port);
      end
   endtask
`else
   task automatic test_pulse_disabled();
      bus_write(3'd5, 32'd7);
      bus_write(3'd4, 32'h0F);
      n_checks++;
      if (out_port !== 8'h55) begin
         n_errors++;
         $display("FAIL disabled_pulse_out: got %h expected 55", out_port);
      end
      for (int a = 4; a < 7; a++) begin
         bus_read(3'(a));
         n_checks++;
         if (bus.readdata !== 32'h0) begin
            n_errors++;
            $display("FAIL disabled_read_addr%0d: got %h expected 00000000", a, bus.readdata);
         end
      end
   endtask
`endif

   initial begin
      reset          = 1'b1;
      bus.address    = 3'd0;
      bus.chipselect = 1'b0;
      bus.read       = 1'b0;
      bus.write_n    = 1'b1;
      bus.writedata  = 32'h0;
      test_reset();
      test_set_clear();
      test_reserved_and_hold();
`ifdef CPU_ASK2_PIO_PULSE_EN
      test_pulse_basic();
      test_back_to_back();
      test_ignored_and_end_retrigger();
      test_writes_during_pulse();
      test_mid_pulse_reset();
`else
      test_pulse_disabled();
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
